// File: rtl/pwm_capture_pkg.sv
// Shared types and constants for the three-channel PWM capture block.
package pwm_capture_pkg;

    typedef enum logic [1:0] {
        ARM     = 2'd0,
        MEASURE = 2'd1,
        STUCK   = 2'd2
    } cap_state_e;

    localparam int NUM_CH = 3;
    localparam int RED    = 0;
    localparam int GREEN  = 1;
    localparam int BLUE   = 2;

    function automatic logic rise_detect(input logic s2, input logic prev);
        return s2 & ~prev;
    endfunction

endpackage

// File: rtl/pwm_capture_chan.sv
// One PWM capture channel: synchronizer, edge detector, measurement FSM,
// period/high-time counters and registered results.
module pwm_capture_chan
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 2**20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic             valid_o,
    output logic             stuck_o
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_C    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONES_C    = {CNT_W{1'b1}};

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             prev_q, prev_d;
    cap_state_e       state_q, state_d;
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             stuck_q, stuck_d;

    logic rise;
    logic timeout;

    assign rise    = rise_detect(s2_q, prev_q);
    assign timeout = (per_cnt_q == TIMEOUT_C);

    // Next-state, counter and result logic for the channel.
    always_comb begin
        s1_d      = pwm_in;
        s2_d      = s1_q;
        prev_d    = s2_q;
        state_d   = state_q;
        per_cnt_d = per_cnt_q;
        hi_cnt_d  = hi_cnt_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        stuck_d   = stuck_q;

        if (!enable) begin
            state_d   = ARM;
            per_cnt_d = ZERO_C;
            hi_cnt_d  = ZERO_C;
            stuck_d   = 1'b0;
        end else begin
            // Counters freeze while stuck and on the cycle that declares it,
            // which keeps them bounded by TIMEOUT.
            if (rise) begin
                per_cnt_d = ONE_C;
                hi_cnt_d  = ONE_C;
            end else if ((state_q != STUCK) && !timeout) begin
                per_cnt_d = per_cnt_q + ONE_C;
                if (s2_q) begin
                    hi_cnt_d = hi_cnt_q + ONE_C;
                end else begin
                    hi_cnt_d = hi_cnt_q;
                end
            end else begin
                per_cnt_d = per_cnt_q;
                hi_cnt_d  = hi_cnt_q;
            end

            case (state_q)
                ARM, MEASURE: begin
                    if (rise) begin
                        state_d = MEASURE;
                        if (state_q == MEASURE) begin
                            period_d = per_cnt_q;
                            high_d   = hi_cnt_q;
                            valid_d  = 1'b1;
                        end else begin
                            valid_d  = 1'b0;
                        end
                    end else if (timeout) begin
                        state_d  = STUCK;
                        period_d = ZERO_C;
                        high_d   = s2_q ? ONES_C : ZERO_C;
                        valid_d  = 1'b1;
                        stuck_d  = 1'b1;
                    end else begin
                        state_d  = state_q;
                    end
                end
                STUCK: begin
                    if (rise) begin
                        state_d = MEASURE;
                        stuck_d = 1'b0;
                    end else begin
                        state_d = STUCK;
                    end
                end
                default: begin
                    state_d   = ARM;
                    per_cnt_d = ZERO_C;
                    hi_cnt_d  = ZERO_C;
                    stuck_d   = 1'b0;
                end
            endcase
        end
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            prev_q    <= 1'b0;
            state_q   <= ARM;
            per_cnt_q <= ZERO_C;
            hi_cnt_q  <= ZERO_C;
            period_q  <= ZERO_C;
            high_q    <= ZERO_C;
            valid_q   <= 1'b0;
            stuck_q   <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            prev_q    <= prev_d;
            state_q   <= state_d;
            per_cnt_q <= per_cnt_d;
            hi_cnt_q  <= hi_cnt_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            stuck_q   <= stuck_d;
        end
    end

    assign period_o = period_q;
    assign high_o   = high_q;
    assign valid_o  = valid_q;
    assign stuck_o  = stuck_q;

endmodule

// File: rtl/pwm_capture.sv
// Three-channel PWM measurement block: one capture channel per colour line,
// results packed channel n at [n*CNT_W +: CNT_W].
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 2**20
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [NUM_CH-1:0]       pwm_in,
    output logic [NUM_CH*CNT_W-1:0] period_o,
    output logic [NUM_CH*CNT_W-1:0] high_o,
    output logic [NUM_CH-1:0]       valid_o,
    output logic [NUM_CH-1:0]       stuck_o
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        pwm_capture_chan #(
            .CNT_W  (CNT_W),
            .TIMEOUT(TIMEOUT)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .enable  (enable),
            .pwm_in  (pwm_in[g]),
            .period_o(period_o[g*CNT_W +: CNT_W]),
            .high_o  (high_o[g*CNT_W +: CNT_W]),
            .valid_o (valid_o[g]),
            .stuck_o (stuck_o[g])
        );
    end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
Three-channel PWM measurement block, the receive-side counterpart of the team's 3-channel PWM generator. It samples three external PWM lines and reports, per channel, the period and high time in clk cycles. It also flags lines stuck high or low. It sits behind the SPI register interface and is used for loopback self-test of the generator and for reading external PWM sources.

Parameters:
CNT_W, 32, width of the period/high-time counters and results.
TIMEOUT, 2**20, cycles without a rising edge before a channel is declared stuck; must be < 2**CNT_W.

Ports:
clk  in  1  system clock; one clock domain.
reset  in  1  synchronous, active-high reset.
enable  in  1  capture enable; low forces all channels idle.
pwm_in  in  3  asynchronous PWM inputs; bit0 red, bit1 green, bit2 blue.
period_o  out  3*CNT_W  last measured period per channel, rising edge to rising edge; channel n at [n*CNT_W +: CNT_W].
high_o  out  3*CNT_W  last measured high time per channel, same packing.
valid_o  out  3  one-cycle pulse per channel when period_o/high_o update.
stuck_o  out  3  level; channel saw no rising edge for TIMEOUT cycles.

Behaviour:
- Reset: synchronous, active-high; the only clock is clk.
- Reset values: period_o=0, high_o=0, valid_o=0, stuck_o=0, sync flops=0, state=ARM, counters=0.
- Each channel is independent and identical.
- Synchronizer: 2-flop (s1, s2) plus a prev flop.
  - These flops run regardless of enable.
  - rise = s2 & ~prev.
- Latency: an input rising edge sampled at clk edge k produces the valid_o pulse in the cycle after edge k+2.
- Counters, when not in reset and enable=1:
  - per_cnt: set to 1 on a rise cycle, otherwise +1.
  - hi_cnt: set to 1 on a rise cycle, otherwise +1 while s2=1, otherwise hold.
  - Both are CNT_W wide. TIMEOUT bounds them, so no wrap occurs.
- States:
  - ARM: discards the partial first period. On rise -> MEASURE, no report. If no rise and per_cnt==TIMEOUT -> STUCK.
  - MEASURE: on rise -> report period_o=per_cnt, high_o=hi_cnt, valid_o=1, restart counters, stay in MEASURE. If no rise and per_cnt==TIMEOUT -> STUCK.
  - STUCK: entered with a report of period_o=0, high_o=all-ones if s2=1 else 0, valid_o=1, stuck_o=1. Counters hold. On rise -> MEASURE, stuck_o=0, no report for that edge.
- Simultaneous events:
  - rise and timeout in the same cycle: rise wins.
  - enable low takes priority over everything except reset.
- enable=0:
  - state forced to ARM, counters cleared, valid_o=0, stuck_o=0.
  - period_o/high_o hold their last values.
- Re-enable while the input is already high: no rise is seen because prev=1. The first reported period starts at the next genuine rise.
- Duty 0% or 100% at the generator is reported as STUCK low or high, not as a period.
- Maximum reportable period is TIMEOUT cycles. high_o <= period_o for every non-stuck report.
- Reset asserted mid-measurement: everything returns to reset values next edge and no valid_o pulse is emitted.

Decomposition:
- Shared package:
  - state enum {ARM, MEASURE, STUCK}.
  - NUM_CH=3.
  - channel index constants RED=0, GREEN=1, BLUE=2.
- Sub-module pwm_capture_chan: one channel (sync, edge detect, FSM, counters, result registers).
- Top instantiates it three times and packs the buses.

Test Plan:
- Reset held 3 cycles with pwm_in toggling -> all outputs 0, no valid_o; after release with enable=0 -> still no valid_o.
- enable=1, pwm_in[0] repeating high 4 / low 12 cycles -> first rise gives no report; each later rise gives valid_o[0] pulse with period_o=16, high_o=4, exactly 3 edges after the input rise.
- Generator loopback with frequency=0 and duty nibbles 4/8/15 -> period_o=256 on all channels; high_o=4, 8, 15 respectively.
- TIMEOUT=100, pwm_in[1] held high after one rise -> valid_o[1] pulse with period_o=0, high_o=all-ones, stuck_o[1]=1; next rise clears stuck_o with no report; the following rise reports a normal period.
- pwm_in[2] held low from enable -> STUCK report with high_o=0 after 100 cycles; enable dropped -> stuck_o=0 and period_o held.
- Rise arriving on the exact timeout cycle -> normal report, stuck_o stays 0; reset pulse mid-period -> no valid_o and outputs cleared.
